// File: rtl/paddle_position.sv
// Paddle position tracker: turns quadrature edge strobes into detent clicks and
// keeps a saturating paddle position with optional 2x acceleration.
module paddle_position #(
  parameter int POS_WIDTH       = 8,
  parameter int POS_MAX         = 27,
  parameter int EDGES_PER_CLICK = 4,
  parameter int WINDOW_CYCLES   = 1048576,
  parameter int FAST_CLICKS     = 6
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 COUNT_ENABLE,
  input  logic                 DIRECTION,
  input  logic                 CENTER,
  output logic [POS_WIDTH-1:0] POSITION,
  output logic                 MOVED,
  output logic                 AT_MIN,
  output logic                 AT_MAX
);

  localparam int ACC_W = $clog2(EDGES_PER_CLICK) + 2;
  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int CNT_W = $clog2(FAST_CLICKS + 1) + 1;

  localparam logic [POS_WIDTH-1:0]    POS_MID  = POS_WIDTH'(POS_MAX / 2);
  localparam logic [POS_WIDTH:0]      POS_TOP  = (POS_WIDTH + 1)'(POS_MAX);
  localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_PLIM = ACC_W'(EDGES_PER_CLICK);
  localparam logic signed [ACC_W-1:0] ACC_NLIM = ACC_W'(-EDGES_PER_CLICK);
  localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_SAT  = CNT_W'(FAST_CLICKS);

  logic                    in_en_q, in_en_d;
  logic                    in_dir_q, in_dir_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    pend_q, pend_d;
  logic                    pend_dir_q, pend_dir_d;
  logic [POS_WIDTH-1:0]    pos_q, pos_d;
  logic                    moved_q, moved_d;
  logic                    fast_q, fast_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_dir_q, last_dir_d;

  logic signed [ACC_W-1:0] acc_step;
  logic                    same_dir;
  logic [POS_WIDTH:0]      step_w;
  logic [POS_WIDTH:0]      pos_sum;
  logic [POS_WIDTH-1:0]    pos_inc;
  logic [POS_WIDTH-1:0]    pos_dec;

  // Candidate saturated positions for the pending click.
  always_comb begin
    same_dir = (pend_dir_q == last_dir_q);
    step_w   = (fast_q && same_dir) ? (POS_WIDTH + 1)'(2) : (POS_WIDTH + 1)'(1);
    pos_sum  = {1'b0, pos_q} + step_w;
    pos_inc  = (pos_sum > POS_TOP) ? POS_TOP[POS_WIDTH-1:0] : pos_sum[POS_WIDTH-1:0];
    pos_dec  = ({1'b0, pos_q} < step_w) ? '0 : pos_q - step_w[POS_WIDTH-1:0];
  end

  always_comb begin
    in_en_d    = COUNT_ENABLE;
    in_dir_d   = DIRECTION;
    acc_d      = acc_q;
    acc_step   = in_dir_q ? (acc_q + ACC_ONE) : (acc_q - ACC_ONE);
    pend_d     = 1'b0;
    pend_dir_d = pend_dir_q;
    pos_d      = pos_q;
    fast_d     = fast_q;
    cnt_d      = cnt_q;
    last_dir_d = last_dir_q;
    win_d      = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);

    if (in_en_q) begin
      if (acc_step == ACC_PLIM) begin
        acc_d      = '0;
        pend_d     = 1'b1;
        pend_dir_d = 1'b1;
      end else if (acc_step == ACC_NLIM) begin
        acc_d      = '0;
        pend_d     = 1'b1;
        pend_dir_d = 1'b0;
      end else begin
        acc_d = acc_step;
      end
    end

    if (pend_q) begin
      last_dir_d = pend_dir_q;
      pos_d      = pend_dir_q ? pos_inc : pos_dec;
      if (same_dir) begin
        if (cnt_q < CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        fast_d = 1'b0;
        cnt_d  = '0;
      end
    end

    // Window boundary decides fast mode for the whole next window.
    if (win_q == WIN_LAST) begin
      fast_d = (FAST_CLICKS != 0) && (cnt_d >= CNT_SAT);
      cnt_d  = '0;
    end

    if (CENTER) begin
      in_en_d    = 1'b0;
      acc_d      = '0;
      pend_d     = 1'b0;
      pos_d      = POS_MID;
      fast_d     = 1'b0;
      cnt_d      = '0;
      last_dir_d = last_dir_q;
    end

    moved_d = (pos_d != pos_q);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      in_en_q    <= 1'b0;
      in_dir_q   <= 1'b0;
      acc_q      <= '0;
      pend_q     <= 1'b0;
      pend_dir_q <= 1'b0;
      pos_q      <= POS_MID;
      moved_q    <= 1'b0;
      fast_q     <= 1'b0;
      win_q      <= '0;
      cnt_q      <= '0;
      last_dir_q <= 1'b1;
    end else begin
      in_en_q    <= in_en_d;
      in_dir_q   <= in_dir_d;
      acc_q      <= acc_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      pos_q      <= pos_d;
      moved_q    <= moved_d;
      fast_q     <= fast_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
    end
  end

  assign POSITION = pos_q;
  assign MOVED    = moved_q;
  assign AT_MIN   = (pos_q == '0);
  assign AT_MAX   = ({1'b0, pos_q} == POS_TOP);

endmodule

// File: doc/paddle_position.md
Name: paddle_position

Overview:
- Consumes the per-clock COUNT_ENABLE/DIRECTION pulse pair produced by the quadrature decoder stage.
- Converts edge pulses into detent clicks: EDGES_PER_CLICK edges make one click.
- Maintains a saturating paddle position for the pong game logic, with optional 2x step acceleration for fast spinning.
- Sits between the quadrature decoder and the paddle/VGA renderer; the entire block is in the CLOCK domain.

Parameters:
- POS_WIDTH, 8, width of POSITION.
- POS_MAX, 27, highest legal position; lowest is 0. Must be < 2**POS_WIDTH.
- EDGES_PER_CLICK, 4, decoder edges per detent click. Must be >= 2.
- WINDOW_CYCLES, 1048576, length of the acceleration measurement window in CLOCK cycles. Must be >= 2.
- FAST_CLICKS, 6, same-direction clicks in one window needed to enable step 2 for the next window. 0 disables acceleration.

Ports:
- CLOCK, in, 1, system clock.
- RESET, in, 1, asynchronous active-high reset.
- COUNT_ENABLE, in, 1, one-cycle edge strobe from the decoder.
- DIRECTION, in, 1, 1 = up (increment), 0 = down; valid only when COUNT_ENABLE is high.
- CENTER, in, 1, synchronous recentre request, level-sampled each cycle.
- POSITION, out, POS_WIDTH, registered paddle position.
- MOVED, out, 1, one-cycle pulse when POSITION changes value.
- AT_MIN, out, 1, POSITION == 0; combinational from the POSITION register.
- AT_MAX, out, 1, POSITION == POS_MAX; combinational from the POSITION register.

Behaviour:
- Reset (asynchronous, active-high):
  - POSITION = POS_MAX/2 (floor; 13 at defaults).
  - MOVED = 0; edge accumulator = 0; click-pending = 0; fast mode = 0; window counter = 0; window click count = 0; last-click direction = up.
- Edge accumulator:
  - Signed, range -(EDGES_PER_CLICK-1)..+(EDGES_PER_CLICK-1).
  - COUNT_ENABLE=1: +1 if DIRECTION=1, else -1.
  - Reaching +EDGES_PER_CLICK: accumulator <= 0 and click-pending(up) is registered on that edge.
  - Reaching -EDGES_PER_CLICK: same, with click-pending(down).
  - Partial rotations that reverse simply cancel; no click is generated.
- Position update (stage 2):
  - The edge after click-pending is set applies POSITION +/- step, saturating at 0 and POS_MAX.
  - Step = 2 if fast mode is set, else 1. At POS_MAX-1 with step 2 going up, the result is POS_MAX (likewise at 1 going down, the result is 0).
- Latency: if the completing COUNT_ENABLE is sampled at edge N, POSITION and MOVED change at edge N+2. Back-to-back clicks on consecutive cycles are each applied; nothing is dropped.
- MOVED: high for exactly the one cycle after a POSITION register change. It stays low if saturation leaves POSITION unchanged.
- Acceleration:
  - The window counter free-runs 0..WINDOW_CYCLES-1 and wraps.
  - A click in the same direction as the last click increments the window click count, saturating at FAST_CLICKS.
  - At wrap: fast mode <= (count >= FAST_CLICKS) and count <= 0.
  - A click opposite to last-click direction clears fast mode and count immediately, and is applied with step 1.
  - Last-click direction updates on every click.
  - Saturated clicks still count.
- CENTER:
  - Sampled high at an edge: POSITION <= POS_MAX/2, accumulator <= 0, click-pending <= 0, fast mode <= 0, count <= 0.
  - MOVED pulses if the value changed.
  - CENTER overrides a simultaneous COUNT_ENABLE or pending click; both are discarded.
  - Held high, CENTER freezes the block at centre.
- Reset asserted mid-click: the partial accumulator and any pending click are lost. No MOVED pulse occurs after deassertion.

Test Plan:
- Reset, then 4 COUNT_ENABLE pulses with DIRECTION=1 at arbitrary spacing -> POSITION 13 -> 14 exactly 2 cycles after the 4th pulse; MOVED high for 1 cycle; AT_MIN/AT_MAX low.
- 3 up pulses, then 3 down pulses, then 3 up pulses -> POSITION stays 13 and MOVED never asserts; a 4th up pulse -> POSITION 14.
- 60 up clicks from reset -> POSITION saturates at 27; AT_MAX=1; further clicks produce no MOVED. Then 1 down click -> 26, AT_MAX=0.
- WINDOW_CYCLES=64, FAST_CLICKS=3: 3 up clicks within one window; after the wrap, the next up click -> +2 (13+3=16 -> 18). An immediate down click -> -1 (17), and fast mode is cleared.
- CENTER asserted on the same edge as the 4th (completing) edge pulse at POSITION 20 -> POSITION 13 at the next edge; MOVED pulse; no later step from the discarded click. The following 3 up pulses do not move POSITION.
- RESET pulsed after 2 up pulses while POSITION=20 -> POSITION 13 asynchronously; 2 further up pulses after release produce no click, and 4 are required.
